// File: rtl/binary_erode.sv
// -----------------------------------------------------------------------------
// binary_erode
//
// Purpose:
//   3x3 morphological erosion of a binarised pixel stream. It sits after the
//   threshold/binarisation stage and in front of the VGA output. Isolated white
//   specks are removed and white regions are thinned by one pixel on each side.
//   The 3x3 window is built from two 1-bit line buffers plus the current row.
//   Output pixel at input position (r,c) is the AND of rows r-2..r and columns
//   c-2..c, so the window is centred on (r-1,c-1). The first two rows and the
//   first two columns of every frame are forced black.
//
//   Data and both sync qualifiers leave the block exactly 3 pclk after they
//   entered it (stage 1: capture/line-buffer read, stage 2: window shift,
//   stage 3: output register).
//
// Build option:
//   BINARY_ERODE_DILATE_EN - when defined the block performs dilation (OR of the
//   9 window bits) instead of erosion. Border forcing, ports, latency and sync
//   behaviour are identical in both builds.
//
// Parameters:
//   H_ACTIVE - active pixels per line, sets the line-buffer depth
//   COL_W    - column counter width, 2**COL_W must be >= H_ACTIVE+1
//
// Ports:
//   pclk       in   pixel clock
//   rst_n      in   synchronous, active-low reset
//   data_bin   in   binary pixel (16'hffff white, 16'h0000 black), bit 0 used
//   hsync_bin  in   high while an active pixel is presented, one per pclk
//   vsync_bin  in   high for the whole active frame
//   data_ero   out  eroded pixel, 16'hffff or 16'h0000
//   hsync_ero  out  hsync_bin delayed 3 pclk
//   vsync_ero  out  vsync_bin delayed 3 pclk
// -----------------------------------------------------------------------------
module binary_erode #(
   parameter int H_ACTIVE = 640,
   parameter int COL_W    = 10
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [15:0] data_bin,
   input  logic        hsync_bin,
   input  logic        vsync_bin,
   output logic [15:0] data_ero,
   output logic        hsync_ero,
   output logic        vsync_ero
);

   localparam int               AW         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [COL_W-1:0] L_H_ACTIVE = COL_W'(H_ACTIVE);
   localparam logic [COL_W-1:0] L_COL_TWO  = COL_W'(2);

   // --------------------------------------------------------------------------
   // Input pixel
   // --------------------------------------------------------------------------
   logic w_p;
   logic w_unused_bits;

   assign w_p           = data_bin[0];
   // Upper data bits are copies of bit 0 on a clean binary stream.
   assign w_unused_bits = ^data_bin[15:1];

   // --------------------------------------------------------------------------
   // Column / row counters
   // r_col and r_row hold the position of the pixel currently on the input.
   // --------------------------------------------------------------------------
   logic [COL_W-1:0] r_col;
   logic [1:0]       r_row;
   logic             r_hs_prev;
   logic [1:0]       w_row;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_hs_prev <= 1'b0;
      end else begin
         r_hs_prev <= hsync_bin;

         if (!hsync_bin) begin
            r_col <= '0;
         end else if (r_col != L_H_ACTIVE) begin
            r_col <= r_col + 1'b1;
         end

         // Advance one row at the end of each line inside the frame.
         if (!vsync_bin) begin
            r_row <= '0;
         end else if (r_hs_prev && !hsync_bin && (r_row != 2'd3)) begin
            r_row <= r_row + 2'd1;
         end
      end
   end

   // A pixel presented while the frame is inactive is treated as row 0 even on
   // the very cycle vsync drops, so it can never produce a white output.
   assign w_row = vsync_bin ? r_row : 2'd0;

   // --------------------------------------------------------------------------
   // Line buffers
   // lb1 holds row r-1, lb2 holds row r-2. Both are read at the current column
   // with registered reads (these read registers are part of stage 1).
   // lb1 is read-first: the old value is captured while p is written.
   // lb2 receives the old lb1 value one cycle later, using the registered lb1
   // read, so neither RAM needs an asynchronous read. The delayed write can
   // never collide with a read of the same column: consecutive pixels always
   // address different columns, and a new line needs at least one hsync-low
   // cycle before the column counter returns to 0.
   // --------------------------------------------------------------------------
   logic             w_lb_en;
   logic [AW-1:0]    w_addr;

   logic             r_lb1 [0:H_ACTIVE-1];
   logic             r_lb2 [0:H_ACTIVE-1];

   logic             r_s1_up1;
   logic             r_s1_up2;
   logic             r_s1_we;
   logic [AW-1:0]    r_s1_addr;

   // Pixels beyond H_ACTIVE are neither read nor written; nothing is written
   // while in reset.
   assign w_lb_en = rst_n && hsync_bin && (r_col < L_H_ACTIVE);
   assign w_addr  = r_col[AW-1:0];

   always_ff @(posedge pclk) begin
      if (w_lb_en) begin
         r_lb1[w_addr] <= w_p;
         r_s1_up1      <= r_lb1[w_addr];
      end
   end

   always_ff @(posedge pclk) begin
      if (r_s1_we) begin
         r_lb2[r_s1_addr] <= r_s1_up1;
      end
      if (w_lb_en) begin
         r_s1_up2 <= r_lb2[w_addr];
      end
   end

   // --------------------------------------------------------------------------
   // Stage 1: capture pixel, position and syncs alongside the line-buffer reads
   // --------------------------------------------------------------------------
   logic             r_s1_p;
   logic [COL_W-1:0] r_s1_col;
   logic [1:0]       r_s1_row;
   logic             r_s1_hs;
   logic             r_s1_vs;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_s1_p    <= 1'b0;
         r_s1_col  <= '0;
         r_s1_row  <= '0;
         r_s1_hs   <= 1'b0;
         r_s1_vs   <= 1'b0;
         r_s1_we   <= 1'b0;
         r_s1_addr <= '0;
      end else begin
         r_s1_p    <= w_p;
         r_s1_col  <= r_col;
         r_s1_row  <= w_row;
         r_s1_hs   <= hsync_bin;
         r_s1_vs   <= vsync_bin;
         r_s1_we   <= w_lb_en;
         r_s1_addr <= w_addr;
      end
   end

   // --------------------------------------------------------------------------
   // Stage 2: 3x3 window
   // r_win[0] is column c-2, r_win[2] is column c. Each entry is the column
   // {row r-2, row r-1, row r}. The window only moves on active pixels, so gaps
   // between pixels never leak into the neighbourhood.
   // The border decision is also made here so stage 3 only needs one flag.
   // --------------------------------------------------------------------------
   logic [2:0] r_win [0:2];
   logic       r_s2_ok;
   logic       r_s2_hs;
   logic       r_s2_vs;
   logic       w_s1_ok;

   assign w_s1_ok = r_s1_hs
                    && (r_s1_row >= 2'd2)
                    && (r_s1_col >= L_COL_TWO)
                    && (r_s1_col <  L_H_ACTIVE);

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            r_win[i] <= '0;
         end
         r_s2_ok <= 1'b0;
         r_s2_hs <= 1'b0;
         r_s2_vs <= 1'b0;
      end else begin
         if (r_s1_hs) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= {r_s1_up2, r_s1_up1, r_s1_p};
         end
         r_s2_ok <= w_s1_ok;
         r_s2_hs <= r_s1_hs;
         r_s2_vs <= r_s1_vs;
      end
   end

   // --------------------------------------------------------------------------
   // Window reduction: per-column reduction, then across the three columns
   // --------------------------------------------------------------------------
   logic [2:0] w_col_red;
   logic       w_win_res;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_col
`ifdef BINARY_ERODE_DILATE_EN
         assign w_col_red[gi] = |r_win[gi];
`else
         assign w_col_red[gi] = &r_win[gi];
`endif
      end
   endgenerate

`ifdef BINARY_ERODE_DILATE_EN
   assign w_win_res = |w_col_red;
`else
   assign w_win_res = &w_col_red;
`endif

   // --------------------------------------------------------------------------
   // Stage 3: output register with border forcing
   // --------------------------------------------------------------------------
   logic r_res;
   logic r_hs3;
   logic r_vs3;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_res <= 1'b0;
         r_hs3 <= 1'b0;
         r_vs3 <= 1'b0;
      end else begin
         r_res <= r_s2_ok && w_win_res;
         r_hs3 <= r_s2_hs;
         r_vs3 <= r_s2_vs;
      end
   end

   assign data_ero  = {16{r_res}};
   assign hsync_ero = r_hs3;
   assign vsync_ero = r_vs3;

endmodule

// File: tb/tb_binary_erode.sv
// -----------------------------------------------------------------------------
// tb_binary_erode
//
// Self-checking bench for binary_erode (H_ACTIVE=8, COL_W=4).
// The driver issues one stream cycle per pclk and pushes the expected output
// for that cycle into a scoreboard queue, tagged with the cycle it must appear.
// The expected pixel is computed from a frame image kept in the bench: the AND
// (OR for the dilation build) of the 3x3 neighbourhood rows l-2..l, columns
// c-2..c, black on the borders. A separate monitor pops and compares.
// A reset kills everything in flight, so the queued expectations are zeroed.
// -----------------------------------------------------------------------------
module tb_binary_erode;

   localparam int H  = 8;
   localparam int CW = 4;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_bin = 16'h0000;
   logic        hsync_bin = 1'b0;
   logic        vsync_bin = 1'b0;
   logic [15:0] data_ero;
   logic        hsync_ero;
   logic        vsync_ero;

   always #5 pclk = ~pclk;

   binary_erode #(
      .H_ACTIVE (H),
      .COL_W    (CW)
   ) dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .data_bin  (data_bin),
      .hsync_bin (hsync_bin),
      .vsync_bin (vsync_bin),
      .data_ero  (data_ero),
      .hsync_ero (hsync_ero),
      .vsync_ero (vsync_ero)
   );

   typedef struct {
      int          due;
      logic [15:0] data;
      logic        hs;
      logic        vs;
      int          l;
      int          c;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   int   frame_no = 0;
   bit   img [0:15][0:15];

   always @(posedge pclk) cyc <= cyc + 1;

   // Morphological result of the 3x3 neighbourhood ending at (l,c).
   function automatic bit ref_pix(input int l, input int c);
      bit acc;
`ifdef BINARY_ERODE_DILATE_EN
      acc = 1'b0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            acc = acc | img[l-dr][c-dc];
`else
      acc = 1'b1;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            acc = acc & img[l-dr][c-dc];
`endif
      return acc;
   endfunction

   // One pclk of stimulus. l/c are the frame line and pixel index (l=-1 when
   // the cycle carries no frame pixel).
   task automatic cycle(input bit rst, input bit hs, input bit vs, input bit p,
                        input int l, input int c);
      exp_t        e;
      exp_t        t;
      logic [15:0] noise;
      bit          white;
      @(negedge pclk);
      noise     = 16'($urandom());
      rst_n     = !rst;
      hsync_bin = hs;
      vsync_bin = vs;
      data_bin  = {noise[15:1], p};
      if (rst) begin
         for (int i = 0; i < q.size(); i++) begin
            t      = q[i];
            t.data = 16'h0000;
            t.hs   = 1'b0;
            t.vs   = 1'b0;
            q[i]   = t;
         end
         e.data = 16'h0000;
         e.hs   = 1'b0;
         e.vs   = 1'b0;
      end else begin
         if (hs && vs && l >= 0 && l < 16 && c >= 0 && c < 16)
            img[l][c] = p;
         white  = hs && vs && (l >= 2) && (c >= 2) && (c < H) && ref_pix(l, c);
         e.data = white ? 16'hffff : 16'h0000;
         e.hs   = hs;
         e.vs   = vs;
      end
      e.due = cyc + 3;
      e.l   = l;
      e.c   = c;
      q.push_back(e);
   endtask

   // mode: 0 all white, 1 white with black at (3,3), 2 black with white at
   // (3,3), 3 random (mostly white). rst_l/rst_c inject a 2-cycle reset at that
   // pixel and abandon the rest of the frame.
   task automatic send_frame(input int mode, input int nlines, input int len,
                             input int rst_l, input int rst_c);
      bit p;
      int gap;
      frame_no++;
      $display("[TB] frame %0d: mode=%0d lines=%0d len=%0d reset_at=(%0d,%0d)",
               frame_no, mode, nlines, len, rst_l, rst_c);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, -1, 0);
      for (int l = 0; l < nlines; l++) begin
         for (int c = 0; c < len; c++) begin
            if (l == rst_l && c == rst_c) begin
               cycle(1'b1, 1'b1, 1'b1, 1'b1, l, c);
               cycle(1'b1, 1'b1, 1'b1, 1'b1, l, c + 1);
               return;
            end
            case (mode)
               0:       p = 1'b1;
               1:       p = !(l == 3 && c == 3);
               2:       p = (l == 3 && c == 3);
               default: p = ($urandom_range(0, 9) < 8);
            endcase
            cycle(1'b0, 1'b1, 1'b1, p, l, c);
         end
         gap = (mode >= 3) ? int'($urandom_range(1, 3)) : 2;
         for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b1, 1'b0, -1, 0);
      end
   endtask

   // Monitor: compare every due expectation against the DUT outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge pclk);
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.due != cyc || data_ero !== e.data || hsync_ero !== e.hs
                || vsync_ero !== e.vs) begin
               fails++;
               $display("FAIL pix l=%0d c=%0d due=%0d now=%0d: got data=%h hs=%b vs=%b, expected data=%h hs=%b vs=%b",
                        e.l, e.c, e.due, cyc, data_ero, hsync_ero, vsync_ero,
                        e.data, e.hs, e.vs);
            end
         end
      end
   end

   initial begin
      int waited;
      // Reset with random inputs: outputs must stay low.
      $display("[TB] reset: 5 pclk with random inputs");
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'($urandom()), 1'($urandom()), 1'($urandom()), -1, 0);

      send_frame(0, 6, H,  -1, -1);
      send_frame(1, 6, H,  -1, -1);
      send_frame(0, 6, 10, -1, -1);
      send_frame(2, 6, H,  -1, -1);

      // Active pixels while the frame is inactive: only the syncs pass.
      $display("[TB] line with hsync high, vsync low");
      for (int c = 0; c < H; c++) cycle(1'b0, 1'b1, 1'b0, 1'b1, -1, c);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 0);

      for (int k = 0; k < 5; k++)
         send_frame(3, int'($urandom_range(4, 8)), int'($urandom_range(H, H + 2)), -1, -1);

      send_frame(0, 6, H, 3, 4);
      send_frame(0, 6, H, -1, -1);
      send_frame(3, 7, H, -1, -1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, -1, 0);

      waited = 0;
      while (q.size() > 0 && waited < 20) begin
         @(negedge pclk);
         waited++;
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations still pending, required 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/binary_erode.md
Name: binary_erode

Overview:
- 3x3 morphological erosion on the binarised pixel stream. Its input is the output of the threshold/binarisation stage.
- Removes isolated white specks and thins white regions before the result is shown on VGA.
- The input stream uses line-valid (hsync) and frame-valid (vsync) qualifiers. The output has the same stream format, delayed by a fixed pipeline latency.
- The 3x3 window is built from two 1-bit line buffers plus the current row.

Parameters:
- H_ACTIVE, 640: active pixels per line; sets line-buffer depth.
- COL_W, 10: column counter width; must satisfy 2^COL_W >= H_ACTIVE+1.

Ports:
- pclk  input  1  pixel clock
- rst_n  input  1  reset: synchronous, active-low; clock pclk
- data_bin  input  16  binary pixel, 16'hffff = white, 16'h0000 = black; only bit 0 is used
- hsync_bin  input  1  high while an active pixel of the current line is presented, one pixel per pclk
- vsync_bin  input  1  high for the whole active frame; low between frames
- data_ero  output  16  eroded pixel, 16'hffff or 16'h0000
- hsync_ero  output  1  hsync_bin delayed 3 pclk
- vsync_ero  output  1  vsync_bin delayed 3 pclk

Behaviour:
- Reset (rst_n=0 at a pclk edge):
  - data_ero=0, hsync_ero=0, vsync_ero=0.
  - Counters, window registers and sync pipeline cleared.
  - Line-buffer RAM is not cleared; stale contents are masked by the row counter.
- Pixel bit: p = data_bin[0].
- Column counter col:
  - 0 when hsync_bin=0.
  - Increments by 1 on each pclk with hsync_bin=1.
  - Saturates at H_ACTIVE.
- Row counter row (2-bit):
  - 0 when vsync_bin=0.
  - Increments on each falling edge of hsync_bin while vsync_bin=1.
  - Saturates at 3.
- Line buffers lb1, lb2 (depth H_ACTIVE, 1 bit):
  - On a valid pixel with col < H_ACTIVE, both buffers are read at address col, in the same cycle as the write.
  - Writes: lb1[col] <= p, lb2[col] <= old lb1[col].
  - Read-before-write: the old contents are used.
  - Pixels with col >= H_ACTIVE are not written.
- Stage 1 (registered): p, col, row, the lb1 read value (row r-1) and the lb2 read value (row r-2), and hsync/vsync.
- Stage 2: the 3x3 window registers shift left one column and load the new 3-bit column {r-2, r-1, r}. The window updates only when the stage-1 hsync is 1.
- Stage 3 (output register):
  - Output pixel at input position (r,c) = AND of all 9 window bits, i.e. rows r-2..r and columns c-2..c (window centred on (r-1,c-1)).
  - Output forced to 0 if r<2, c<2, c>=H_ACTIVE, or the delayed hsync=0.
  - data_ero = {16{result}}.
- Latency: exactly 3 pclk from input to output, for data and both syncs. hsync/vsync pass through unchanged apart from the delay.
- Border pixels (first two rows, first two columns) are always 0.
- Line or frame shorter than nominal: handled; counters restart on the next hsync/vsync low.
- Reset mid-frame:
  - Outputs go to 0 on the next edge.
  - After release, processing resumes at the next pixel with row=0/col=0 semantics, so the first two rows and columns seen are black.
- hsync_bin high while vsync_bin=0: row stays 0, output data 0, syncs still delayed.

Optional Feature:
- Macro: BINARY_ERODE_DILATE_EN.
- Defined: the block performs dilation instead of erosion.
  - Stage 3 uses the OR of the 9 window bits.
  - Border forcing to 0 is unchanged.
- Undefined: erosion (AND) as specified above.
- Ports, latency and sync behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 5 pclk with random inputs -> data_ero=0, hsync_ero=0, vsync_ero=0 throughout; the first post-reset output lines have rows 0-1 black.
- All-white frame (H_ACTIVE=8, 6 lines, data_bin=16'hffff) -> data_ero=16'hffff exactly at rows 2..5, cols 2..7, 0 elsewhere; outputs lag hsync_bin/vsync_bin by 3 pclk.
- All-white frame with one black pixel at (3,3) -> data_ero=0 at rows 3..5, cols 3..5 plus the borders; 16'hffff at every other position with r>=2, c>=2.
- Line of 10 pixels with H_ACTIVE=8, all white -> cols 8 and 9 output 0; cols 0..7 behave as in the all-white case.
- Reset asserted at row 3, col 4 of an all-white frame, released 2 pclk later, stream continues as a new frame -> outputs 0 during reset; the next two rows are black; white resumes at row 2, col 2 of the new count.
- BINARY_ERODE_DILATE_EN build: all-black frame with one white pixel at (3,3) -> data_ero=16'hffff at rows 3..5, cols 3..5, 0 elsewhere.
